// File: rtl/ila_trigger_seq.sv
// Multi-stage trigger sequencer feeding one ila_core trigger bit.
// Each stage compares signal_i against a value/mask pair and must see a programmed number of
// consecutive matching cycles before the sequence advances. Completing the last stage emits a
// one-cycle registered trigger pulse.
// Optional feature: define ILA_TRIGGER_SEQ_TIMEOUT_EN to add timeout_i, which returns a stalled
// sequence (stage > 0) to stage 0 after a programmed number of enabled cycles.
module ila_trigger_seq #(
  parameter int unsigned SIGNAL_W = 32,
  parameter int unsigned N_STAGES = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic                          cke_i,
  input  logic [SIGNAL_W-1:0]           signal_i,
  input  logic [N_STAGES*SIGNAL_W-1:0]  stage_value_i,
  input  logic [N_STAGES*SIGNAL_W-1:0]  stage_mask_i,
  input  logic [N_STAGES*CNT_W-1:0]     stage_count_i,
  input  logic [$clog2(N_STAGES)-1:0]   last_stage_i,
`ifdef ILA_TRIGGER_SEQ_TIMEOUT_EN
  input  logic [CNT_W-1:0]              timeout_i,
`endif
  input  logic                          arm_i,
  input  logic                          disarm_i,
  output logic                          trigger_o,
  output logic                          armed_o,
  output logic                          done_o,
  output logic [$clog2(N_STAGES)-1:0]   stage_o
);

  localparam int unsigned STAGE_W = $clog2(N_STAGES);
  localparam logic [STAGE_W-1:0] LastIdx = STAGE_W'(N_STAGES - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StFired} state_e;

  state_e              state_q;
  logic [STAGE_W-1:0]  stage_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [STAGE_W-1:0]  last_eff;
  logic [SIGNAL_W-1:0] sel_value;
  logic [SIGNAL_W-1:0] sel_mask;
  logic [CNT_W-1:0]    sel_count;
  logic [CNT_W-1:0]    eff_count;
  logic [CNT_W:0]      cnt_inc;
  logic                match;
  logic                stage_done;
  logic                timeout_hit;

  assign stage_o = stage_q;

  // Select the active stage's pattern and decide whether this cycle completes the stage.
  always_comb begin
    last_eff   = (last_stage_i >= LastIdx) ? LastIdx : last_stage_i;
    sel_value  = stage_value_i[32'(stage_q) * SIGNAL_W +: SIGNAL_W];
    sel_mask   = stage_mask_i[32'(stage_q) * SIGNAL_W +: SIGNAL_W];
    sel_count  = stage_count_i[32'(stage_q) * CNT_W +: CNT_W];
    eff_count  = (sel_count == '0) ? CNT_W'(1) : sel_count;
    match      = ((signal_i ^ sel_value) & sel_mask) == '0;
    cnt_inc    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    stage_done = cnt_inc >= {1'b0, eff_count};
  end

`ifdef ILA_TRIGGER_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] tcnt_q;
  logic [CNT_W:0]   tcnt_inc;
  logic             stage_adv;

  // Timeout fires on the cycle the stall count would reach timeout_i; zero disables it.
  always_comb begin
    tcnt_inc    = {1'b0, tcnt_q} + (CNT_W + 1)'(1);
    timeout_hit = (state_q == StArmed) && (stage_q != '0) && (timeout_i != '0) &&
                  (tcnt_inc >= {1'b0, timeout_i});
    stage_adv   = (state_q == StArmed) && match && stage_done && (stage_q < last_eff);
  end

  // Stall counter: cleared on every stage entry, counts enabled cycles spent in stages > 0.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tcnt_q <= '0;
    end else if (cke_i) begin
      if (disarm_i || arm_i || (state_q != StArmed) || timeout_hit || stage_adv) begin
        tcnt_q <= '0;
      end else if (stage_q != '0) begin
        tcnt_q <= tcnt_inc[CNT_W-1:0];
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Sequencer FSM with registered trigger/armed/done outputs; cke_i low freezes everything.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= StIdle;
      stage_q   <= '0;
      cnt_q     <= '0;
      trigger_o <= 1'b0;
      armed_o   <= 1'b0;
      done_o    <= 1'b0;
    end else if (cke_i) begin
      trigger_o <= 1'b0;
      if (disarm_i) begin
        state_q <= StIdle;
        stage_q <= '0;
        cnt_q   <= '0;
        armed_o <= 1'b0;
        done_o  <= 1'b0;
      end else if (arm_i) begin
        state_q <= StArmed;
        stage_q <= '0;
        cnt_q   <= '0;
        armed_o <= 1'b1;
        done_o  <= 1'b0;
      end else if (state_q == StArmed) begin
        if (timeout_hit) begin
          stage_q <= '0;
          cnt_q   <= '0;
        end else if (match) begin
          if (stage_done) begin
            cnt_q <= '0;
            // >= rather than == so a last_stage lowered mid-sequence still terminates.
            if (stage_q >= last_eff) begin
              state_q   <= StFired;
              trigger_o <= 1'b1;
              armed_o   <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              stage_q <= stage_q + STAGE_W'(1);
            end
          end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ila_trigger_seq.sv
// Self-checking bench for ila_trigger_seq: vector table, directed corner sequences and
// randomized stimulus against a behavioural model.
module tb_ila_trigger_seq;

  localparam int W  = 8;
  localparam int NS = 3;
  localparam int CW = 4;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              arst, cke, arm, disarm;
  logic [W-1:0]      sig;
  logic [NS*W-1:0]   sv, sm;
  logic [NS*CW-1:0]  sc;
  logic [SW-1:0]     last;
  logic              trigger, armed, done;
  logic [SW-1:0]     stage;
`ifdef ILA_TRIGGER_SEQ_TIMEOUT_EN
  logic [CW-1:0]     timeout;
  int                cfg_to;
`endif

  ila_trigger_seq #(.SIGNAL_W(W), .N_STAGES(NS), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .arst_i        (arst),
    .cke_i         (cke),
    .signal_i      (sig),
    .stage_value_i (sv),
    .stage_mask_i  (sm),
    .stage_count_i (sc),
    .last_stage_i  (last),
`ifdef ILA_TRIGGER_SEQ_TIMEOUT_EN
    .timeout_i     (timeout),
`endif
    .arm_i         (arm),
    .disarm_i      (disarm),
    .trigger_o     (trigger),
    .armed_o       (armed),
    .done_o        (done),
    .stage_o       (stage)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] cfg_val[NS];
  logic [W-1:0] cfg_msk[NS];
  int           cfg_cnt[NS];
  int           cfg_last;

  // Model state: 0 idle, 1 armed, 2 fired
  int m_state, m_stage, m_cnt, m_tcnt;
  bit m_trig;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < NS; k++) begin
      sv[k*W +: W]   = cfg_val[k];
      sm[k*W +: W]   = cfg_msk[k];
      sc[k*CW +: CW] = CW'(cfg_cnt[k]);
    end
    last = SW'(cfg_last);
`ifdef ILA_TRIGGER_SEQ_TIMEOUT_EN
    timeout = CW'(cfg_to);
`endif
  endtask

  function automatic void model_reset();
    m_state = 0; m_stage = 0; m_cnt = 0; m_tcnt = 0; m_trig = 0;
  endfunction

  // One enabled clock edge, straight from the behavioural rules.
  function automatic void model_step();
    int lst, need;
    bit entry;
    if (!cke) return;
    m_trig = 0;
    if (disarm) begin
      m_state = 0; m_stage = 0; m_cnt = 0; m_tcnt = 0;
      return;
    end
    if (arm) begin
      m_state = 1; m_stage = 0; m_cnt = 0; m_tcnt = 0;
      return;
    end
    if (m_state != 1) return;
    lst = (cfg_last > NS - 1) ? NS - 1 : cfg_last;
`ifdef ILA_TRIGGER_SEQ_TIMEOUT_EN
    if (m_stage > 0 && cfg_to != 0 && m_tcnt + 1 >= cfg_to) begin
      m_stage = 0; m_cnt = 0; m_tcnt = 0;
      return;
    end
`endif
    need  = (cfg_cnt[m_stage] == 0) ? 1 : cfg_cnt[m_stage];
    entry = 0;
    if (((sig ^ cfg_val[m_stage]) & cfg_msk[m_stage]) == 0) begin
      m_cnt++;
      if (m_cnt >= need) begin
        m_cnt = 0;
        if (m_stage >= lst) begin
          m_state = 2; m_trig = 1;
        end else begin
          m_stage++; entry = 1;
        end
      end
    end else begin
      m_cnt = 0;
    end
    if (entry || m_state != 1) m_tcnt = 0;
    else if (m_stage > 0) m_tcnt++;
  endfunction

  // Advance one clock, then compare every output against the model.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("m_trigger", int'(trigger), int'(m_trig));
    chk("m_armed",   int'(armed),   int'(m_state == 1));
    chk("m_done",    int'(done),    int'(m_state == 2));
    chk("m_stage",   int'(stage),   m_stage);
  endtask

  typedef struct {
    bit           arm;
    bit           disarm;
    bit           cke;
    logic [W-1:0] sig;
    bit           t;
    bit           a;
    bit           d;
    int           st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit ar, bit di, bit ck, logic [W-1:0] s, bit t, bit a, bit d,
                              int st);
    vec_t v;
    v.arm = ar; v.disarm = di; v.cke = ck; v.sig = s; v.t = t; v.a = a; v.d = d; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic drive(input bit ar, input bit di, input bit ck, input logic [W-1:0] s);
    arm = ar; disarm = di; cke = ck; sig = s;
  endtask

  task automatic cfg_seq123();
    for (int k = 0; k < NS; k++) begin
      cfg_val[k] = W'(k + 1);
      cfg_msk[k] = 8'hFF;
      cfg_cnt[k] = 1;
    end
    cfg_last = 2;
    apply_cfg();
  endtask

  initial begin
    for (int k = 0; k < NS; k++) begin
      cfg_val[k] = '0; cfg_msk[k] = '0; cfg_cnt[k] = 0;
    end
    cfg_last = 0;
`ifdef ILA_TRIGGER_SEQ_TIMEOUT_EN
    cfg_to = 0;
`endif
    apply_cfg();
    drive(0, 0, 1, '0);
    arst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_armed",   int'(armed),   0);
    chk("rst_done",    int'(done),    0);
    chk("rst_stage",   int'(stage),   0);
    arst = 1'b0;

    // Single stage, 0xA5 under full mask, three consecutive matches.
    cfg_val[0] = 8'hA5; cfg_msk[0] = 8'hFF; cfg_cnt[0] = 3; cfg_last = 0;
    apply_cfg();
    //  arm dis cke sig    trig armed done stage
    add(1, 0, 1, 8'h00, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 1, 0, 1, 0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 0);
    add(1, 0, 1, 8'h00, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 0, 1, 0, 0);
    add(0, 0, 1, 8'h00, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 1, 0, 1, 0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 0);
    add(1, 0, 1, 8'h00, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 8'hA5, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 0, 1, 0, 0);
    add(1, 1, 1, 8'hA5, 0, 0, 0, 0);
    add(0, 0, 1, 8'hA5, 0, 0, 0, 0);
    add(1, 0, 1, 8'h00, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 0, 1, 0, 0);
    add(0, 0, 1, 8'hA5, 1, 0, 1, 0);
    add(0, 0, 0, 8'h00, 1, 0, 1, 0);
    add(0, 0, 0, 8'h00, 1, 0, 1, 0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].arm, vecs[i].disarm, vecs[i].cke, vecs[i].sig);
      tick();
      chk($sformatf("vec%0d_trigger", i), int'(trigger), int'(vecs[i].t));
      chk($sformatf("vec%0d_armed", i),   int'(armed),   int'(vecs[i].a));
      chk($sformatf("vec%0d_done", i),    int'(done),    int'(vecs[i].d));
      chk($sformatf("vec%0d_stage", i),   int'(stage),   vecs[i].st);
    end

    // Three stages walked in order, then no re-trigger while fired.
    cfg_seq123();
    drive(1, 0, 1, 8'h00); tick();
    drive(0, 0, 1, 8'h01); tick(); chk("seq_stage1", int'(stage), 1);
    chk("seq_no_trig1", int'(trigger), 0);
    drive(0, 0, 1, 8'h02); tick(); chk("seq_stage2", int'(stage), 2);
    drive(0, 0, 1, 8'h03); tick(); chk("seq_trigger", int'(trigger), 1);
    chk("seq_done", int'(done), 1);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 1, W'(i)); tick();
      chk("seq_no_retrigger", int'(trigger), 0);
      chk("seq_still_done", int'(done), 1);
    end

    // Asynchronous reset while armed at stage 2.
    drive(1, 0, 1, 8'h00); tick();
    drive(0, 0, 1, 8'h01); tick();
    drive(0, 0, 1, 8'h02); tick(); chk("ar_pre_stage", int'(stage), 2);
    #2 arst = 1'b1;
    #1;
    model_reset();
    chk("ar_trigger", int'(trigger), 0);
    chk("ar_armed",   int'(armed),   0);
    chk("ar_done",    int'(done),    0);
    chk("ar_stage",   int'(stage),   0);
    #1 arst = 1'b0;
    drive(0, 0, 1, 8'h03); tick(); chk("ar_stays_idle", int'(armed), 0);

`ifdef ILA_TRIGGER_SEQ_TIMEOUT_EN
    // Stage 1 never matches; after four stalled cycles the sequence restarts at stage 0.
    cfg_to = 4;
    cfg_seq123();
    drive(1, 0, 1, 8'h00); tick();
    drive(0, 0, 1, 8'h01); tick(); chk("to_stage1", int'(stage), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 8'h00); tick(); chk("to_hold", int'(stage), 1);
    end
    drive(0, 0, 1, 8'h00); tick();
    chk("to_back0", int'(stage), 0);
    chk("to_no_trig", int'(trigger), 0);
    chk("to_armed", int'(armed), 1);
`endif

    // Randomized run; configuration only changes together with a disarm.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        for (int k = 0; k < NS; k++) begin
          cfg_val[k] = W'($urandom);
          cfg_msk[k] = ($urandom_range(0, 7) == 0) ? '0 : (W'($urandom) & W'($urandom));
          cfg_cnt[k] = $urandom_range(0, 3);
        end
        cfg_last = $urandom_range(0, 3);
`ifdef ILA_TRIGGER_SEQ_TIMEOUT_EN
        cfg_to = $urandom_range(0, 6);
`endif
        apply_cfg();
        disarm = 1'b1;
      end else begin
        disarm = ($urandom_range(0, 99) < 2);
      end
      arm = ($urandom_range(0, 99) < 6);
      cke = ($urandom_range(0, 99) < 85);
      if (m_state == 1 && $urandom_range(0, 99) < 70)
        sig = cfg_val[m_stage] ^ (W'($urandom) & ~cfg_msk[m_stage]);
      else
        sig = W'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
